dma_addr_seq_ctrl: RTL and testbench
====================================

// Module: dma_addr_seq_ctrl
// PURPOSE
//   Registered sequencer for the DMA addressing path: holds the present-state register and steps it once per clock.
//   Drives the 3-bit address-control code (adctl) and memory-request strobe.
//   Resolves X/Y index skips, the page-crossing fix-up cycle and the read-modify-write extension.
//   Sits between the bus-request front end (start/done handshake) and the address adder/memory port.
// PARAMETERS
//   WAIT_MAX  15  consecutive mem_ready=0 cycles in a memory state before timeout
//   CNT_W     6   width of op_cycles counter
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   start      in   1      request; accepted only when busy=0
//   xskip      in   1      1 = skip X index add (sampled on accept)
//   yskip      in   1      1 = skip Y index add (sampled on accept)
//   rmw_b      in   1      0 = read-modify-write op (sampled on accept)
//   page       in   1      page crossing from adder, sampled in ADD_X/ADD_Y only
//   mem_ready  in   1      memory completes current access this cycle
//   abort      in   1      cancel operation
//   busy       out  1      state != IDLE
//   mem_req    out  1      1 in FETCH_LO, FETCH_HI, READ, WRITE
//   mem_wr     out  1      1 in WRITE only
//   adctl      out  3      address-control code of current state
//   state      out  4      present-state register
//   done       out  1      1-cycle pulse in DONE
//   err        out  1      1-cycle pulse on timeout
//   op_cycles  out  CNT_W  non-IDLE cycle count of current/last op
// BEHAVIOUR
//   Reset: state=IDLE; busy=mem_req=mem_wr=done=err=0; adctl=3'b000; op_cycles=0; captured flags=0.
//   States/adctl: IDLE 0/000, FETCH_LO 1/001, FETCH_HI 2/010, ADD_X 3/011, ADD_Y 4/100,
//     PAGE_FIX 5/101, READ 6/110, MODIFY 7/111, WRITE 8/110, DONE 9/000. Codes 10-15 illegal -> IDLE next cycle.
//   IDLE: start=1 -> capture xskip/yskip/rmw_b; set y_pend=~yskip; clear op_cycles; go FETCH_LO.
//   FETCH_LO: mem_ready -> FETCH_HI, else hold.
//   FETCH_HI: mem_ready -> ADD_X if ~xskip_q; else ADD_Y if y_pend; else READ. Otherwise hold.
//   ADD_X: page=1 -> PAGE_FIX; else ADD_Y if y_pend; else READ.
//   ADD_Y: clear y_pend; page=1 -> PAGE_FIX, else READ.
//   PAGE_FIX: one cycle -> ADD_Y if y_pend, else READ.
//   READ: mem_ready -> MODIFY if rmw_b_q=0, else DONE.
//   MODIFY: one cycle -> WRITE.
//   WRITE: mem_ready -> DONE.
//   DONE: done=1 -> IDLE. start in DONE is ignored (busy=1).
//   All outputs are decoded from the registered state (Moore); no combinational input-to-output path.
//   Min latency (abs, no rmw, ready=1): accept edge -> done high 4 cycles later; op_cycles=4 during done.
//   op_cycles: +1 each non-IDLE cycle; saturates at 2^CNT_W-1; holds its value in IDLE until next accept.
//   Timeout: wait counter increments while mem_req=1 and mem_ready=0, clears on ready or state change.
//     Reaching WAIT_MAX -> err pulse, next state IDLE, no done.
//   abort=1 in any non-IDLE state -> IDLE next cycle, no done/err. Abort has priority over timeout and normal transitions.
//   abort in IDLE is ignored; abort and start together in IDLE -> start wins.
//   rst mid-operation overrides everything, including abort.
// STRUCTURE
//   Shared package dma_seq_pkg: state enum (4-bit codes above), ADCTL_* localparams, is_mem_state() function.
//   Sub-module dma_wait_timer (count, clear, expire at WAIT_MAX); the FSM and counter are kept in the top module.
// TESTING
//   Reset with state forced mid-op: rst=1 for 1 cycle -> state=0, adctl=000, all strobes 0.
//   start, xskip=yskip=1, rmw_b=1, ready=1 -> states 1,2,6,9,0; done at cycle 4; op_cycles=4.
//   start, xskip=0, yskip=0, page=1 in ADD_X only -> 1,2,3,5,4,6,9; op_cycles=7.
//   rmw_b=0, xskip=yskip=1, ready low 2 cycles in READ -> 1,2,6,6,6,7,8,9; mem_wr high only in 8.
//   ready held 0 in FETCH_LO with WAIT_MAX=15 -> err pulse after 15 wait cycles, then IDLE, no done.
//   abort in ADD_Y together with page=1 -> IDLE next cycle; done=0; start next cycle accepted.

Source files
------------

// File: rtl/dma_addr_seq_ctrl_pkg.sv
// Shared types for the DMA address sequencer: state encoding, address-control
// codes and small decode helpers used by the sequencer and its timer.
package dma_seq_pkg;

    // Present-state encoding. The 4-bit codes are visible on the state port.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH_LO = 4'd1,
        ST_FETCH_HI = 4'd2,
        ST_ADD_X    = 4'd3,
        ST_ADD_Y    = 4'd4,
        ST_PAGE_FIX = 4'd5,
        ST_READ     = 4'd6,
        ST_MODIFY   = 4'd7,
        ST_WRITE    = 4'd8,
        ST_DONE     = 4'd9
    } seq_state_e;

    // Address-control codes presented to the address adder / memory port.
    localparam logic [2:0] ADCTL_IDLE     = 3'b000;
    localparam logic [2:0] ADCTL_FETCH_LO = 3'b001;
    localparam logic [2:0] ADCTL_FETCH_HI = 3'b010;
    localparam logic [2:0] ADCTL_ADD_X    = 3'b011;
    localparam logic [2:0] ADCTL_ADD_Y    = 3'b100;
    localparam logic [2:0] ADCTL_PAGE_FIX = 3'b101;
    localparam logic [2:0] ADCTL_MEM      = 3'b110;
    localparam logic [2:0] ADCTL_MODIFY   = 3'b111;

    // States that hold a memory request open and may stall on mem_ready.
    function automatic logic is_mem_state(input seq_state_e s);
        return (s == ST_FETCH_LO) || (s == ST_FETCH_HI) ||
               (s == ST_READ)     || (s == ST_WRITE);
    endfunction

    // READ and WRITE share one code; the memory port tells them apart by mem_wr.
    function automatic logic [2:0] adctl_of(input seq_state_e s);
        logic [2:0] code;
        case (s)
            ST_FETCH_LO: code = ADCTL_FETCH_LO;
            ST_FETCH_HI: code = ADCTL_FETCH_HI;
            ST_ADD_X:    code = ADCTL_ADD_X;
            ST_ADD_Y:    code = ADCTL_ADD_Y;
            ST_PAGE_FIX: code = ADCTL_PAGE_FIX;
            ST_READ:     code = ADCTL_MEM;
            ST_MODIFY:   code = ADCTL_MODIFY;
            ST_WRITE:    code = ADCTL_MEM;
            default:     code = ADCTL_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/dma_addr_seq_ctrl_if.sv
// Request/handshake and memory-side bundle of the DMA address sequencer.
// master = bus-request front end side, slave = the sequencer itself.
interface dma_addr_seq_ctrl_if #(
    parameter int CNT_W = 6
) ();

    logic             start;
    logic             xskip;
    logic             yskip;
    logic             rmw_b;
    logic             page;
    logic             mem_ready;
    logic             abort;

    logic             busy;
    logic             mem_req;
    logic             mem_wr;
    logic [2:0]       adctl;
    logic [3:0]       state;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] op_cycles;

    modport master (
        output start, xskip, yskip, rmw_b, page, mem_ready, abort,
        input  busy, mem_req, mem_wr, adctl, state, done, err, op_cycles
    );

    modport slave (
        input  start, xskip, yskip, rmw_b, page, mem_ready, abort,
        output busy, mem_req, mem_wr, adctl, state, done, err, op_cycles
    );

endinterface

// File: rtl/dma_addr_seq_ctrl_wait_timer.sv
// Memory-wait watchdog: counts consecutive stalled cycles and flags the
// cycle that would be the WAIT_MAX-th one, so the sequencer can leave on
// the very next edge.
module dma_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expire
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] cnt_q;

    // Stall counter; never needs to pass LAST because expiry forces a state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = count_en && (cnt_q == LAST);

endmodule

// File: rtl/dma_addr_seq_ctrl.sv
// DMA addressing-path sequencer. Steps through fetch / index-add / page-fix /
// read[-modify-write] for each accepted request, drives the address-control
// code and memory strobes as pure Moore decodes of the state register, and
// tracks how many non-idle cycles the current (or last) operation took.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | waiting for start, flags and op_cycles held
// FETCH_LO | memory fetch of pointer low byte
// FETCH_HI | memory fetch of pointer high byte
// ADD_X    | add X index (skipped when xskip captured)
// ADD_Y    | add Y index (only while y_pend)
// PAGE_FIX | extra cycle to fix the high byte after a page carry
// READ     | operand read
// MODIFY   | internal modify cycle of a read-modify-write
// WRITE    | write-back of a read-modify-write
// DONE     | one-cycle completion pulse
module dma_addr_seq_ctrl
    import dma_seq_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 6
) (
    input logic               clk,
    input logic               rst,
    dma_addr_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] OP_MAX = '1;

    seq_state_e       state_q;
    seq_state_e       state_d;

    logic             xskip_q;
    logic             rmw_b_q;
    logic             y_pend_q;
    logic             err_q;
    logic [CNT_W-1:0] op_cycles_q;

    logic             wait_cond;
    logic             timer_clear;
    logic             timer_expire;
    logic             timeout;

    logic             busy;
    logic             mem_req;
    logic             mem_wr;
    logic             done;
    logic [2:0]       adctl;

    // A stall is any cycle with an open request that memory did not complete.
    assign wait_cond   = is_mem_state(state_q) && !bus.mem_ready;
    assign timer_clear = !wait_cond || (state_d != state_q);
    assign timeout     = timer_expire && !bus.abort;

    dma_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .count_en (wait_cond),
        .clear    (timer_clear),
        .expire   (timer_expire)
    );

    // Present-state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; abort and timeout are applied last so they win.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_FETCH_LO;
            end
            ST_FETCH_LO: begin
                if (bus.mem_ready) state_d = ST_FETCH_HI;
            end
            ST_FETCH_HI: begin
                if (bus.mem_ready) begin
                    if (!xskip_q)     state_d = ST_ADD_X;
                    else if (y_pend_q) state_d = ST_ADD_Y;
                    else               state_d = ST_READ;
                end
            end
            ST_ADD_X: begin
                if (bus.page)      state_d = ST_PAGE_FIX;
                else if (y_pend_q) state_d = ST_ADD_Y;
                else               state_d = ST_READ;
            end
            ST_ADD_Y: begin
                state_d = bus.page ? ST_PAGE_FIX : ST_READ;
            end
            ST_PAGE_FIX: begin
                state_d = y_pend_q ? ST_ADD_Y : ST_READ;
            end
            ST_READ: begin
                if (bus.mem_ready) state_d = rmw_b_q ? ST_DONE : ST_MODIFY;
            end
            ST_MODIFY: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (bus.mem_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timer_expire) state_d = ST_IDLE;
        if (bus.abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    // Captured request flags, pending-Y marker, error pulse and cycle counter.
    // op_cycles counts the cycle being entered, so it already includes the
    // current cycle while the sequencer sits in any non-idle state.
    always_ff @(posedge clk) begin
        if (rst) begin
            xskip_q     <= 1'b0;
            rmw_b_q     <= 1'b0;
            y_pend_q    <= 1'b0;
            err_q       <= 1'b0;
            op_cycles_q <= '0;
        end else begin
            err_q <= timeout;
            if ((state_q == ST_IDLE) && bus.start) begin
                xskip_q     <= bus.xskip;
                rmw_b_q     <= bus.rmw_b;
                y_pend_q    <= !bus.yskip;
                op_cycles_q <= CNT_W'(1);
            end else begin
                if (state_q == ST_ADD_Y) y_pend_q <= 1'b0;
                if ((state_d != ST_IDLE) && (op_cycles_q != OP_MAX)) begin
                    op_cycles_q <= op_cycles_q + 1'b1;
                end
            end
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        busy    = (state_q != ST_IDLE);
        mem_req = is_mem_state(state_q);
        mem_wr  = (state_q == ST_WRITE);
        done    = (state_q == ST_DONE);
        adctl   = adctl_of(state_q);
    end

    assign bus.busy      = busy;
    assign bus.mem_req   = mem_req;
    assign bus.mem_wr    = mem_wr;
    assign bus.done      = done;
    assign bus.adctl     = adctl;
    assign bus.state     = 4'(state_q);
    assign bus.err       = err_q;
    assign bus.op_cycles = op_cycles_q;

endmodule

// File: tb/tb_dma_addr_seq_ctrl.sv
// Directed bench for dma_addr_seq_ctrl. Each queue entry holds the inputs to
// drive in one cycle and the outputs expected in that same cycle.
module tb_dma_addr_seq_ctrl;

    localparam int CNT_W   = 6;
    localparam int OP_SAT  = (1 << CNT_W) - 1;

    localparam logic [3:0] S_IDLE = 4'd0, S_FLO = 4'd1, S_FHI = 4'd2, S_AX = 4'd3,
                           S_AY = 4'd4, S_PF = 4'd5, S_RD = 4'd6, S_MOD = 4'd7,
                           S_WR = 4'd8, S_DONE = 4'd9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dma_addr_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    dma_addr_seq_ctrl #(
        .WAIT_MAX (15),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] st;
        int         op;
        logic       er;
        logic       rdy;
        logic       pg;
        logic       ab;
        logic       sin;
        logic       rs;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [2:0] ref_adctl(input logic [3:0] s);
        case (s)
            4'd1:    return 3'b001;
            4'd2:    return 3'b010;
            4'd3:    return 3'b011;
            4'd4:    return 3'b100;
            4'd5:    return 3'b101;
            4'd6:    return 3'b110;
            4'd7:    return 3'b111;
            4'd8:    return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > OP_SAT) ? OP_SAT : v;
    endfunction

    task automatic push(input logic [3:0] st, input int op, input logic rdy = 1'b0,
                        input logic pg = 1'b0, input logic ab = 1'b0, input logic sin = 1'b0,
                        input logic rs = 1'b0, input logic er = 1'b0);
        exp_t e;
        e.st = st; e.op = op; e.er = er; e.rdy = rdy;
        e.pg = pg; e.ab = ab; e.sin = sin; e.rs = rs;
        exp_q.push_back(e);
    endtask

    // 14 stalled cycles then completion: one short of the timeout.
    task automatic push_wait(input logic [3:0] st, input int op0);
        for (int k = 0; k < 14; k++) push(st, sat(op0 + k), 1'b0);
        push(st, sat(op0 + 14), 1'b1);
    endtask

    task automatic chk(input string tag, input string what, input logic [31:0] got,
                       input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s %s: got %0d, expected %0d", tag, what, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rst           = e.rs;
            bus.start     = e.sin;
            bus.mem_ready = e.rdy;
            bus.page      = e.pg;
            bus.abort     = e.ab;
            chk(tag, "state",     32'(bus.state),     32'(e.st));
            chk(tag, "adctl",     32'(bus.adctl),     32'(ref_adctl(e.st)));
            chk(tag, "busy",      32'(bus.busy),      32'(e.st != S_IDLE));
            chk(tag, "mem_req",   32'(bus.mem_req),
                32'(e.st == S_FLO || e.st == S_FHI || e.st == S_RD || e.st == S_WR));
            chk(tag, "mem_wr",    32'(bus.mem_wr),    32'(e.st == S_WR));
            chk(tag, "done",      32'(bus.done),      32'(e.st == S_DONE));
            chk(tag, "err",       32'(bus.err),       32'(e.er));
            chk(tag, "op_cycles", 32'(bus.op_cycles), 32'(e.op));
            tick();
        end
    endtask

    task automatic set_flags(input logic xs, input logic ys, input logic rmwb);
        bus.xskip = xs;
        bus.yskip = ys;
        bus.rmw_b = rmwb;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.page = 1'b0; bus.mem_ready = 1'b0; bus.abort = 1'b0;
        set_flags(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        tick();

        // reset values, then release
        push(S_IDLE, 0);
        run("reset");

        // shortest path, start during DONE ignored
        set_flags(1'b1, 1'b1, 1'b1);
        push(S_IDLE, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        push(S_FLO, 1, 1'b1);
        push(S_FHI, 2, 1'b1);
        push(S_RD, 3, 1'b1);
        push(S_DONE, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        push(S_IDLE, 4);
        run("min_path");

        // X and Y adds with page fix after ADD_X only
        set_flags(1'b0, 1'b0, 1'b1);
        push(S_IDLE, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        push(S_FLO, 1, 1'b1);
        push(S_FHI, 2, 1'b1);
        push(S_AX, 3, 1'b0, 1'b1);
        push(S_PF, 4);
        push(S_AY, 5);
        push(S_RD, 6, 1'b1);
        push(S_DONE, 7);
        push(S_IDLE, 7);
        run("xy_page");

        // read-modify-write with two stalled read cycles
        set_flags(1'b1, 1'b1, 1'b0);
        push(S_IDLE, 7, 1'b1, 1'b0, 1'b0, 1'b1);
        push(S_FLO, 1, 1'b1);
        push(S_FHI, 2, 1'b1);
        push(S_RD, 3, 1'b0);
        push(S_RD, 4, 1'b0);
        push(S_RD, 5, 1'b1);
        push(S_MOD, 6);
        push(S_WR, 7, 1'b1);
        push(S_DONE, 8);
        push(S_IDLE, 8);
        run("rmw");

        // memory never ready in FETCH_LO: 15 stalls then err, no done
        set_flags(1'b1, 1'b1, 1'b1);
        push(S_IDLE, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 15; i++) push(S_FLO, i, 1'b0);
        push(S_IDLE, 15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(S_IDLE, 15);
        run("timeout");

        // abort with page in ADD_Y, then start+abort in IDLE: start wins
        set_flags(1'b1, 1'b0, 1'b1);
        push(S_IDLE, 15, 1'b1, 1'b0, 1'b0, 1'b1);
        push(S_FLO, 1, 1'b1);
        push(S_FHI, 2, 1'b1);
        push(S_AY, 3, 1'b0, 1'b1, 1'b1);
        push(S_IDLE, 3, 1'b1, 1'b0, 1'b1, 1'b1);
        push(S_FLO, 1, 1'b1);
        push(S_FHI, 2, 1'b1);
        push(S_AY, 3);
        push(S_RD, 4, 1'b1);
        push(S_DONE, 5);
        push(S_IDLE, 5);
        run("abort");

        // longest path: stalls just under the limit, op_cycles saturates
        set_flags(1'b0, 1'b0, 1'b0);
        push(S_IDLE, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        push_wait(S_FLO, 1);
        push_wait(S_FHI, 16);
        push(S_AX, 31, 1'b0, 1'b1);
        push(S_PF, 32);
        push(S_AY, 33, 1'b0, 1'b1);
        push(S_PF, 34);
        push_wait(S_RD, 35);
        push(S_MOD, 50);
        push_wait(S_WR, 51);
        push(S_DONE, OP_SAT);
        push(S_IDLE, OP_SAT);
        run("saturate");

        // reset mid-operation overrides abort; lone abort in IDLE ignored
        set_flags(1'b1, 1'b1, 1'b1);
        push(S_IDLE, OP_SAT, 1'b0, 1'b0, 1'b0, 1'b1);
        push(S_FLO, 1, 1'b0);
        push(S_FLO, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        push(S_IDLE, 0, 1'b0, 1'b0, 1'b1);
        push(S_IDLE, 0);
        run("mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
